// File: rtl/lenet_pool_pkg.sv
// Shared types and widths for the LeNet 2x2 max-pool sequencer.
package lenet_pool_pkg;

  localparam int unsigned ADDR_W   = 14;
  localparam int unsigned DATA_W   = 16;
  localparam int unsigned CH_W     = 5;
  localparam int unsigned POOL_LAT = 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } pool_state_t;

endpackage

// File: rtl/pool_addr_gen.sv
// Window counters and incremental read/write address generation for one pooling run.
module pool_addr_gen
  import lenet_pool_pkg::*;
#(
  parameter int unsigned IMG_W  = 24,
  parameter int unsigned IMG_H  = 24,
  parameter int unsigned MAX_CH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_step,
  input  logic [CH_W-1:0]   i_cfg_ch,
  input  logic [ADDR_W-1:0] i_in_base,
  input  logic [ADDR_W-1:0] i_out_base,
  output logic [ADDR_W-1:0] o_rd_addr_t,
  output logic [ADDR_W-1:0] o_rd_addr_b,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic              o_last_c
);

  localparam int unsigned OUT_W = IMG_W / 2;
  localparam int unsigned OUT_H = IMG_H / 2;
  localparam int unsigned COL_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int unsigned ROW_W = (OUT_H > 1) ? $clog2(OUT_H) : 1;

  localparam logic [COL_W-1:0]  COL_LAST = COL_W'(OUT_W - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(OUT_H - 1);
  localparam logic [CH_W-1:0]   CH_MAX   = CH_W'(MAX_CH);
  localparam logic [ADDR_W-1:0] ROW_OFS  = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] STEP_COL = ADDR_W'(2);
  // Leaving a row pair (or a whole channel) skips the bottom row: +IMG_W+2 either way.
  localparam logic [ADDR_W-1:0] STEP_ROW = ADDR_W'(IMG_W + 2);

  logic [COL_W-1:0]  r_ocol;
  logic [ROW_W-1:0]  r_orow;
  logic [CH_W-1:0]   r_ch;
  logic [CH_W-1:0]   r_ch_last;
  logic [ADDR_W-1:0] r_rd_addr_t;
  logic [ADDR_W-1:0] r_rd_addr_b;
  logic [ADDR_W-1:0] r_wr_addr;

  logic              w_col_last;
  logic              w_row_last;
  logic [CH_W-1:0]   w_ch_sat;

  assign w_col_last = (r_ocol == COL_LAST);
  assign w_row_last = (r_orow == ROW_LAST);
  assign w_ch_sat   = (i_cfg_ch > CH_MAX) ? CH_MAX : i_cfg_ch;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ocol      <= '0;
      r_orow      <= '0;
      r_ch        <= '0;
      r_ch_last   <= '0;
      r_rd_addr_t <= '0;
      r_rd_addr_b <= '0;
      r_wr_addr   <= '0;
    end else if (i_load) begin
      r_ocol      <= '0;
      r_orow      <= '0;
      r_ch        <= '0;
      r_ch_last   <= w_ch_sat - CH_W'(1);
      r_rd_addr_t <= i_in_base;
      r_rd_addr_b <= i_in_base + ROW_OFS;
      r_wr_addr   <= i_out_base;
    end else if (i_step) begin
      r_wr_addr <= r_wr_addr + ADDR_W'(1);
      if (w_col_last) begin
        r_ocol      <= '0;
        r_rd_addr_t <= r_rd_addr_t + STEP_ROW;
        r_rd_addr_b <= r_rd_addr_b + STEP_ROW;
        if (w_row_last) begin
          r_orow <= '0;
          r_ch   <= r_ch + CH_W'(1);
        end else begin
          r_orow <= r_orow + ROW_W'(1);
        end
      end else begin
        r_ocol      <= r_ocol + COL_W'(1);
        r_rd_addr_t <= r_rd_addr_t + STEP_COL;
        r_rd_addr_b <= r_rd_addr_b + STEP_COL;
      end
    end
  end

  assign o_rd_addr_t = r_rd_addr_t;
  assign o_rd_addr_b = r_rd_addr_b;
  assign o_wr_addr   = r_wr_addr;
  assign o_last_c    = w_col_last & w_row_last & (r_ch == r_ch_last);

endmodule

// File: rtl/maxpool_2x2_ctrl.sv
// Sequencer for the 2x2 max-pool datapath: issues one window per cycle and writes results back.
module maxpool_2x2_ctrl
  import lenet_pool_pkg::*;
#(
  parameter int unsigned IMG_W  = 24,
  parameter int unsigned IMG_H  = 24,
  parameter int unsigned MAX_CH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [ADDR_W-1:0] in_base,
  input  logic [ADDR_W-1:0] out_base,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr_t,
  output logic [ADDR_W-1:0] rd_addr_b,
  output logic              max_en,
  input  logic [DATA_W-1:0] max_out,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data
);

  pool_state_t       r_state;
  logic              r_busy;
  logic              r_done;
  logic              r_rd_en;
  logic [POOL_LAT-1:0] r_vld;
  logic [ADDR_W-1:0] r_wa [POOL_LAT];

  logic              w_load;
  logic              w_step;
  logic              w_last;
  logic [ADDR_W-1:0] w_wr_addr_iss;

  assign w_load = (r_state == S_IDLE) && start;
  assign w_step = (r_state == S_ISSUE) && !w_last;

  pool_addr_gen #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .MAX_CH (MAX_CH)
  ) u_addr_gen (
    .clk         (clk),
    .rst         (rst),
    .i_load      (w_load),
    .i_step      (w_step),
    .i_cfg_ch    (cfg_ch),
    .i_in_base   (in_base),
    .i_out_base  (out_base),
    .o_rd_addr_t (rd_addr_t),
    .o_rd_addr_b (rd_addr_b),
    .o_wr_addr   (w_wr_addr_iss),
    .o_last_c    (w_last)
  );

  // Run control; DONE coincides with the final write so done lands one cycle after it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_rd_en <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_busy <= 1'b1;
            if (cfg_ch != '0) begin
              r_state <= S_ISSUE;
              r_rd_en <= 1'b1;
            end else begin
              r_state <= S_DONE;
            end
          end
        end
        S_ISSUE: begin
          if (w_last) begin
            r_state <= S_DRAIN;
            r_rd_en <= 1'b0;
          end
        end
        S_DRAIN: begin
          if (!r_vld[0]) r_state <= S_DONE;
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Valid and write-address delay line matching the datapath latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld <= '0;
      for (int i = 0; i < int'(POOL_LAT); i++) r_wa[i] <= '0;
    end else begin
      r_vld   <= {r_vld[POOL_LAT-2:0], r_rd_en};
      r_wa[0] <= w_wr_addr_iss;
      for (int i = 1; i < int'(POOL_LAT); i++) r_wa[i] <= r_wa[i-1];
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign rd_en   = r_rd_en;
  assign max_en  = r_vld[0];
  assign wr_en   = r_vld[POOL_LAT-1];
  assign wr_addr = r_wa[POOL_LAT-1];
  assign wr_data = max_out;

endmodule
